// File: rtl/mont_enc_if.sv
// Handshake bundle for mont_enc: an input coefficient channel and a result channel.
interface mont_enc_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [DATA_W-1:0] a_in;
    logic              out_valid;
    logic              out_ready;
    logic              out_mode;
    logic [DATA_W-1:0] a_out;

    modport master (
        output in_valid, mode, a_in, out_ready,
        input  in_ready, out_valid, out_mode, a_out
    );

    modport slave (
        input  in_valid, mode, a_in, out_ready,
        output in_ready, out_valid, out_mode, a_out
    );
endinterface

// File: rtl/mont_enc.sv
// Montgomery-domain encoder: a_out = a_in * R mod q (Kyber or Dilithium per transaction), 3-stage pipeline.
// Optional signed input handling and the sticky err_range output are enabled by MONT_ENC_SIGNED_IN_EN.
module mont_enc #(
    parameter int DATA_W = 24,
    parameter int PROD_W = 46
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MONT_ENC_SIGNED_IN_EN
    output logic err_range,
`endif
    mont_enc_if.slave bus
);
    localparam logic [23:0] K_Q  = 24'd3329;
    localparam logic [23:0] D_Q  = 24'd8380417;
    localparam logic [15:0] K_R2 = 16'd2385;
    localparam logic [15:0] D_R2 = 16'd49145;
    localparam logic [22:0] K_QP = 23'd3327;
    localparam logic [22:0] D_QP = 23'd8380415;

    logic              s1_valid, s2_valid, s3_valid;
    logic              s1_mode, s2_mode, s3_mode;
    logic [PROD_W-1:0] s1_t;
    logic [DATA_W-1:0] s2_u, s3_a;
    logic              s1_ready, s2_ready, s3_ready, accept;

    logic [22:0]       a_op;
    logic [15:0]       r2;
    logic [PROD_W-1:0] t_next;

    logic [23:0]       q1, q2;
    logic [22:0]       qp, t_lo, m_full, m_red;
    logic [47:0]       mq_sum;
    logic [DATA_W-1:0] u_next, a_red;

    // A stage may load whenever it is empty or its occupant moves on this cycle.
    assign s3_ready = !s3_valid || bus.out_ready;
    assign s2_ready = !s2_valid || s3_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign accept   = bus.in_valid && s1_ready;

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s3_valid;
    assign bus.out_mode  = s3_mode;
    assign bus.a_out     = s3_a;

`ifdef MONT_ENC_SIGNED_IN_EN
    logic [24:0] q_in, a_sx, a_adj;
    logic        a_bad;
    logic        unused_bits;

    // Negative inputs are lifted by q so the multiplier always sees a value in [0, q).
    always_comb begin
        q_in  = bus.mode ? {1'b0, D_Q} : {1'b0, K_Q};
        a_sx  = bus.mode ? {bus.a_in[23], bus.a_in} : {{12{bus.a_in[12]}}, bus.a_in[12:0]};
        a_adj = a_sx[24] ? a_sx + q_in : a_sx;
        a_bad = a_sx[24] ? (a_adj[24] || (a_adj == 25'd0)) : (a_sx >= q_in);
        a_op  = bus.mode ? a_adj[22:0] : {11'b0, a_adj[11:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (accept && a_bad) begin
            err_range <= 1'b1;
        end
    end

    assign unused_bits = ^{mq_sum[47], mq_sum[11:0], a_adj[23]};
`else
    logic unused_bits;

    assign a_op        = bus.mode ? bus.a_in[22:0] : {11'b0, bus.a_in[11:0]};
    assign unused_bits = ^{mq_sum[47], mq_sum[11:0], bus.a_in[23]};
`endif

    always_comb begin
        r2     = bus.mode ? D_R2 : K_R2;
        t_next = PROD_W'(a_op) * PROD_W'(r2);
    end

    // Montgomery reduction; the low log2(R) bits of the sum are zero by construction.
    always_comb begin
        q1     = s1_mode ? D_Q : K_Q;
        qp     = s1_mode ? D_QP : K_QP;
        t_lo   = s1_mode ? s1_t[22:0] : {11'b0, s1_t[11:0]};
        m_full = t_lo * qp;
        m_red  = s1_mode ? m_full : {11'b0, m_full[11:0]};
        mq_sum = {2'b0, s1_t} + ({25'b0, m_red} * {24'b0, q1});
        u_next = s1_mode ? mq_sum[46:23] : mq_sum[35:12];
    end

    always_comb begin
        q2    = s2_mode ? D_Q : K_Q;
        a_red = (s2_u >= q2) ? s2_u - q2 : s2_u;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_t     <= '0;
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_u     <= '0;
            s3_valid <= 1'b0;
            s3_mode  <= 1'b0;
            s3_a     <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_mode <= bus.mode;
                    s1_t    <= t_next;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mode <= s1_mode;
                    s2_u    <= u_next;
                end
            end
            if (s3_ready) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_mode <= s2_mode;
                    s3_a    <= a_red;
                end
            end
        end
    end
endmodule
